// File: rtl/truth_table_seq_if.sv
// Run-control bundle of the truth-table sequencer. The master starts a run; the slave reports the verdict.
// The obs_tt signal exists only when TT_LOG_EN is defined.
interface truth_table_seq_if #(parameter int N_IN = 2);
   logic                 start;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [N_IN:0]        err_cnt;
   logic                 fail_vld;
   logic [N_IN-1:0]      fail_vec;
`ifdef TT_LOG_EN
   logic [2**N_IN-1:0]   obs_tt;
   modport master (output start, input busy, done, pass, err_cnt, fail_vld, fail_vec, obs_tt);
   modport slave  (input start, output busy, done, pass, err_cnt, fail_vld, fail_vec, obs_tt);
`else
   modport master (output start, input busy, done, pass, err_cnt, fail_vld, fail_vec);
   modport slave  (input start, output busy, done, pass, err_cnt, fail_vld, fail_vec);
`endif
endinterface

// File: rtl/truth_table_seq.sv
// Clocked stimulus and capture stage for a combinational gate. It walks every input vector and checks each response.
// Define TT_LOG_EN to add the observed-truth-table output obs_tt.
//
// state | meaning
// IDLE  | waiting for start; the results of the last run are held
// WAIT  | the vector is driven; SETTLE cycles are counted before sampling
// CHECK | dut_out_i is compared with EXPECT[vec_o]; the FSM then advances or finishes
// FIN   | busy drops, done pulses and pass is latched
module truth_table_seq #(
   parameter int                 N_IN   = 2,
   parameter int                 SETTLE = 1,
   parameter logic [2**N_IN-1:0] EXPECT = 4'b1110
) (
   input  logic                  clk,
   input  logic                  rst_n,
   truth_table_seq_if.slave      ctl,
   output logic [N_IN-1:0]       vec_o,
   input  logic                  dut_out_i
);
   localparam int NV = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_FIN} state_t;

   state_t            state_q;
   logic [N_IN-1:0]   vec_q;
   logic [CW-1:0]     cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [N_IN:0]     err_q;
   logic              fvld_q;
   logic [N_IN-1:0]   fvec_q;
`ifdef TT_LOG_EN
   logic [NV-1:0]     obs_q;
`endif
   logic              miss;

   // A case-inequality compare makes an X or Z response count as a mismatch.
   assign miss = (dut_out_i !== EXPECT[vec_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fvld_q  <= 1'b0;
         fvec_q  <= '0;
`ifdef TT_LOG_EN
         obs_q   <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (ctl.start) begin
                  vec_q   <= '0;
                  cnt_q   <= '0;
                  err_q   <= '0;
                  fvld_q  <= 1'b0;
                  fvec_q  <= '0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
`ifdef TT_LOG_EN
                  obs_q   <= '0;
`endif
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(SETTLE - 1)) state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (miss) begin
                  if (err_q != (N_IN+1)'(NV)) err_q <= err_q + 1'b1;
                  if (!fvld_q) begin
                     fvld_q <= 1'b1;
                     fvec_q <= vec_q;
                  end
               end
`ifdef TT_LOG_EN
               obs_q[vec_q] <= (dut_out_i === 1'b1);
`endif
               if (vec_q == {N_IN{1'b1}}) begin
                  state_q <= S_FIN;
               end else begin
                  vec_q   <= vec_q + 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_FIN: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= (err_q == '0);
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign vec_o        = vec_q;
   assign ctl.busy     = busy_q;
   assign ctl.done     = done_q;
   assign ctl.pass     = pass_q;
   assign ctl.err_cnt  = err_q;
   assign ctl.fail_vld = fvld_q;
   assign ctl.fail_vec = fvec_q;
`ifdef TT_LOG_EN
   assign ctl.obs_tt   = obs_q;
`endif

endmodule

// File: tb/tb_truth_table_seq.sv
// Bench for truth_table_seq. Gate models drive the sequencer, and a scoreboard holds the expected verdict of each run.
// When TT_LOG_EN is defined, the observed truth table is checked as well.
module tb_truth_table_seq;
   localparam int N_IN = 2;
   localparam int M_OR = 0, M_AND = 1, M_XOR = 2, M_NOR = 3, M_ZERO = 4, M_ONE = 5, M_INV = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   truth_table_seq_if #(.N_IN(N_IN)) bus  ();
   truth_table_seq_if #(.N_IN(N_IN)) bus3 ();
   logic [N_IN-1:0] vec, vec3;
   logic            dut_out, dut_out3;
   logic [3:0]      exp_tt = 4'b1110;
   int              mode = M_OR;

   truth_table_seq #(.N_IN(N_IN), .SETTLE(1), .EXPECT(4'b1110)) u_dut (
      .clk(clk), .rst_n(rst_n), .ctl(bus.slave), .vec_o(vec), .dut_out_i(dut_out));

   truth_table_seq #(.N_IN(N_IN), .SETTLE(3), .EXPECT(4'b1110)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ctl(bus3.slave), .vec_o(vec3), .dut_out_i(dut_out3));

   always_comb begin
      dut_out = 1'b0;
      case (mode)
         M_OR:   dut_out = vec[1] | vec[0];
         M_AND:  dut_out = vec[1] & vec[0];
         M_XOR:  dut_out = vec[1] ^ vec[0];
         M_NOR:  dut_out = ~(vec[1] | vec[0]);
         M_ZERO: dut_out = 1'b0;
         M_ONE:  dut_out = 1'b1;
         M_INV:  dut_out = ~exp_tt[vec];
         default: dut_out = 1'b0;
      endcase
   end
   // Two-state simulators collapse X, so the SETTLE=3 unit sees an always-wrong response instead.
   assign dut_out3 = ~exp_tt[vec3];

   typedef struct {
      int         mode;
      int         err;
      bit         fvld;
      int         fvec;
      bit         pass;
      logic [3:0] obs;
   } row_t;

   row_t rows [7];
   row_t sb_q [$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Pulse start and follow the run to done; extra_at re-asserts start so it is sampled at that edge.
   task automatic run(input row_t r, input int extra_at, output int done_edge);
      row_t exp_r;
      bit   seq_ok;
      mode = r.mode;
      sb_q.push_back(r);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      seq_ok = (vec === 2'd0) && (bus.busy === 1'b1);
      done_edge = -1;
      for (int e = 1; e <= 40; e++) begin
         if (e == extra_at) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (e <= 8) begin
            if (vec !== N_IN'((e < 8) ? e / 2 : 3) || bus.busy !== 1'b1) seq_ok = 0;
         end
         if (bus.done === 1'b1) begin
            done_edge = e;
            break;
         end
      end
      exp_r = sb_q.pop_front();
      chk("done_edge", done_edge, 9);
      chk("vec_sequence", seq_ok, 1);
      chk("busy_at_done", bus.busy, 0);
      chk("err_cnt", bus.err_cnt, exp_r.err);
      chk("fail_vld", bus.fail_vld, exp_r.fvld);
      chk("fail_vec", bus.fail_vec, exp_r.fvec);
      chk("pass", bus.pass, exp_r.pass);
`ifdef TT_LOG_EN
      chk("obs_tt", bus.obs_tt, exp_r.obs);
`endif
   endtask

   task automatic count_dones(input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) n++;
      end
   endtask

   initial begin
      int de, nd, d1, d2;
      bit busy_ok;
      bus.start  = 1'b0;
      bus3.start = 1'b0;
      rows[0] = '{M_OR,   0, 1'b0, 0, 1'b1, 4'b1110};
      rows[1] = '{M_AND,  2, 1'b1, 1, 1'b0, 4'b1000};
      rows[2] = '{M_XOR,  1, 1'b1, 3, 1'b0, 4'b0110};
      rows[3] = '{M_NOR,  4, 1'b1, 0, 1'b0, 4'b0001};
      rows[4] = '{M_ZERO, 3, 1'b1, 1, 1'b0, 4'b0000};
      rows[5] = '{M_ONE,  1, 1'b1, 0, 1'b0, 4'b1111};
      rows[6] = '{M_INV,  4, 1'b1, 0, 1'b0, 4'b0001};

      #3;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pass", bus.pass, 0);
      chk("rst_err_cnt", bus.err_cnt, 0);
      chk("rst_vec", vec, 0);
      chk("rst_fail", {bus.fail_vld, bus.fail_vec}, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run(rows[i], -1, de);

      // Results stay frozen in IDLE until the next start.
      repeat (3) @(posedge clk);
      #1;
      chk("hold_vec", vec, 3);
      chk("hold_err_cnt", bus.err_cnt, 4);
      chk("hold_done_low", bus.done, 0);

      run(rows[0], 4, de);
      count_dones(12, nd);
      chk("ignored_start_dones", nd, 0);

      // With start held high, runs follow back to back; the second run's done comes at edge 19.
      mode = M_OR;
      bus.start = 1'b1;
      d1 = -1; d2 = -1; busy_ok = 0;
      @(posedge clk); #1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (e == 10) busy_ok = (bus.done === 1'b0) && (bus.busy === 1'b1);
         if (bus.done === 1'b1) begin
            if (d1 < 0) d1 = e;
            else begin
               d2 = e;
               break;
            end
         end
      end
      bus.start = 1'b0;
      chk("b2b_first_done", d1, 9);
      chk("b2b_second_done", d2, 19);
      chk("b2b_done_falls", busy_ok, 1);
      chk("b2b_pass", bus.pass, 1);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a failing run clears everything at once.
      mode = M_AND;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_reset_err_cnt", bus.err_cnt, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_err_cnt", bus.err_cnt, 0);
      chk("mid_rst_vec", vec, 0);
      chk("mid_rst_fail_vld", bus.fail_vld, 0);
      chk("mid_rst_pass_done", {bus.pass, bus.done}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      count_dones(12, nd);
      chk("post_reset_no_done", nd, 0);
      run(rows[0], -1, de);

      bus3.start = 1'b1;
      @(posedge clk); #1;
      bus3.start = 1'b0;
      de = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (bus3.done === 1'b1) begin
            de = e;
            break;
         end
      end
      chk("settle3_done_edge", de, 17);
      chk("settle3_err_cnt", bus3.err_cnt, 4);
      chk("settle3_fail_vec", bus3.fail_vec, 0);
      chk("settle3_fail_vld", bus3.fail_vld, 1);
      chk("settle3_pass", bus3.pass, 0);
`ifdef TT_LOG_EN
      chk("settle3_obs_tt", bus3.obs_tt, 4'b0001);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
